// File: rtl/sc_buttonconditioner_jug1.sv
// Player-1 key conditioner: 2-flop sync, counter debounce, active-low level, press strobe.
// Define SC_BUTTONCONDITIONER_JUG1_AUTOREPEAT_EN for left/right auto-repeat while held.
module sc_buttonconditioner_jug1 #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_GAP      = 4
) (
    input  logic       SC_BUTTONCONDITIONER_JUG1_CLOCK_50,
    input  logic       SC_BUTTONCONDITIONER_JUG1_RESET_InLow,
    input  logic       SC_BUTTONCONDITIONER_JUG1_startRaw_InLow,
    input  logic       SC_BUTTONCONDITIONER_JUG1_leftRaw_InLow,
    input  logic       SC_BUTTONCONDITIONER_JUG1_rightRaw_InLow,
    output logic       SC_BUTTONCONDITIONER_JUG1_startButton_OutLow,
    output logic       SC_BUTTONCONDITIONER_JUG1_leftButton_OutLow,
    output logic       SC_BUTTONCONDITIONER_JUG1_rightButton_OutLow,
    output logic [2:0] SC_BUTTONCONDITIONER_JUG1_pressPulse_Out
);

    localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

`ifdef SC_BUTTONCONDITIONER_JUG1_AUTOREPEAT_EN
    localparam int RW = (REPEAT_DELAY > 2) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [RW-1:0] HOLD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] GAP_LAST  = RW'(REPEAT_GAP - 1);

    typedef enum logic [2:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT,
        ST_GAP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;
`endif

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES >= (1 << CNT_WIDTH) ||
        REPEAT_GAP < 2 || REPEAT_DELAY < 1) begin : g_bad_param
        $error("sc_buttonconditioner_jug1: illegal parameter combination");
    end

    logic       clk;
    logic       rst_n;
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] pulse;

    assign clk   = SC_BUTTONCONDITIONER_JUG1_CLOCK_50;
    assign rst_n = SC_BUTTONCONDITIONER_JUG1_RESET_InLow;
    assign raw   = {SC_BUTTONCONDITIONER_JUG1_startRaw_InLow,
                    SC_BUTTONCONDITIONER_JUG1_leftRaw_InLow,
                    SC_BUTTONCONDITIONER_JUG1_rightRaw_InLow};

    // Bit order follows pressPulse_Out: 2 = start, 1 = left, 0 = right.
    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic                 sync1_q;
        logic                 sync2_q;
        state_t               state_q;
        state_t               state_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;
        logic                 out_q;
        logic                 out_d;
        logic                 pulse_q;
        logic                 pulse_d;
`ifdef SC_BUTTONCONDITIONER_JUG1_AUTOREPEAT_EN
        localparam bit REP_OK = (i != 2);
        logic [RW-1:0]        rep_q;
        logic [RW-1:0]        rep_d;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                state_q <= ST_RELEASED;
                cnt_q   <= '0;
                out_q   <= 1'b1;
                pulse_q <= 1'b0;
`ifdef SC_BUTTONCONDITIONER_JUG1_AUTOREPEAT_EN
                rep_q   <= '0;
`endif
            end else begin
                sync1_q <= raw[i];
                sync2_q <= sync1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                pulse_q <= pulse_d;
`ifdef SC_BUTTONCONDITIONER_JUG1_AUTOREPEAT_EN
                rep_q   <= rep_d;
`endif
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
            pulse_d = 1'b0;
`ifdef SC_BUTTONCONDITIONER_JUG1_AUTOREPEAT_EN
            rep_d   = '0;
`endif
            unique case (state_q)
                ST_RELEASED: begin
                    if (!sync2_q) begin
                        state_d = ST_PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (sync2_q) begin
                        state_d = ST_RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                        out_d   = 1'b0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (sync2_q) begin
                        state_d = ST_RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
`ifdef SC_BUTTONCONDITIONER_JUG1_AUTOREPEAT_EN
                    else if (REP_OK) begin
                        if (rep_q == HOLD_LAST) begin
                            state_d = ST_GAP;
                            out_d   = 1'b1;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
`endif
                end
                ST_RELEASE_WAIT: begin
                    if (!sync2_q) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = ST_RELEASED;
                        cnt_d   = '0;
                        out_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef SC_BUTTONCONDITIONER_JUG1_AUTOREPEAT_EN
                // Forced release window; a real release here still debounces.
                ST_GAP: begin
                    if (sync2_q) begin
                        state_d = ST_RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                        out_d   = 1'b0;
                    end else if (rep_q == GAP_LAST) begin
                        state_d = ST_PRESSED;
                        out_d   = 1'b0;
                        pulse_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                end
            endcase
        end

        assign lvl[i]   = out_q;
        assign pulse[i] = pulse_q;
    end

    assign SC_BUTTONCONDITIONER_JUG1_startButton_OutLow = lvl[2];
    assign SC_BUTTONCONDITIONER_JUG1_leftButton_OutLow  = lvl[1];
    assign SC_BUTTONCONDITIONER_JUG1_rightButton_OutLow = lvl[0];
    assign SC_BUTTONCONDITIONER_JUG1_pressPulse_Out     = pulse;

endmodule

// File: tb/tb_sc_buttonconditioner_jug1.sv
// Bench for sc_buttonconditioner_jug1: directed scenarios plus random keys vs a run-length model.
// Honours SC_BUTTONCONDITIONER_JUG1_AUTOREPEAT_EN when defined.
module tb_sc_buttonconditioner_jug1;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RG = 4;
`ifdef SC_BUTTONCONDITIONER_JUG1_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_raw = 1'b1;
    logic       l_raw = 1'b1;
    logic       r_raw = 1'b1;
    logic       s_o;
    logic       l_o;
    logic       r_o;
    logic [2:0] pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sc_buttonconditioner_jug1 #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_WIDTH(4),
        .REPEAT_DELAY(RD),
        .REPEAT_GAP(RG)
    ) dut (
        .SC_BUTTONCONDITIONER_JUG1_CLOCK_50(clk),
        .SC_BUTTONCONDITIONER_JUG1_RESET_InLow(rst_n),
        .SC_BUTTONCONDITIONER_JUG1_startRaw_InLow(s_raw),
        .SC_BUTTONCONDITIONER_JUG1_leftRaw_InLow(l_raw),
        .SC_BUTTONCONDITIONER_JUG1_rightRaw_InLow(r_raw),
        .SC_BUTTONCONDITIONER_JUG1_startButton_OutLow(s_o),
        .SC_BUTTONCONDITIONER_JUG1_leftButton_OutLow(l_o),
        .SC_BUTTONCONDITIONER_JUG1_rightButton_OutLow(r_o),
        .SC_BUTTONCONDITIONER_JUG1_pressPulse_Out(pulse)
    );

    // Reference: a level flips after DB consecutive synchronised samples that
    // disagree with it; a held key (AR builds, left/right) opens a gap every RD.
    logic [2:0] m_d1, m_s, m_lvl, m_pulse, m_out;
    int m_run[3];
    int m_hold[3];
    int m_gap[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = '1; m_s = '1; m_lvl = '1; m_pulse = '0; m_out = '1;
            for (int i = 0; i < 3; i++) begin
                m_run[i] = 0; m_hold[i] = 0; m_gap[i] = 0;
            end
        end else begin
            m_pulse = '0;
            for (int i = 0; i < 3; i++) begin
                if (m_gap[i] > 0) begin
                    if (m_s[i]) begin
                        m_gap[i] = 0;
                        m_run[i] = 1;
                    end else begin
                        m_gap[i]--;
                        if (m_gap[i] == 0) m_pulse[i] = 1'b1;
                    end
                end else if (m_s[i] != m_lvl[i]) begin
                    m_hold[i] = 0;
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = m_s[i];
                        m_run[i] = 0;
                        m_pulse[i] = !m_lvl[i];
                    end
                end else if (m_run[i] > 0) begin
                    m_run[i] = 0;
                end else if (AR && i < 2 && !m_lvl[i]) begin
                    m_hold[i]++;
                    if (m_hold[i] == RD) begin
                        m_hold[i] = 0;
                        m_gap[i] = RG;
                    end
                end
                m_out[i] = m_lvl[i] | (m_gap[i] > 0);
            end
            m_s = m_d1;
            m_d1 = {s_raw, l_raw, r_raw};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_raw = 1'b1; l_raw = 1'b1; r_raw = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        l_raw = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if ({s_o, l_o, r_o, pulse} !== 6'b111000) begin
                errors++;
                $display("FAIL reset_hold: got %b want 111000", {s_o, l_o, r_o, pulse});
            end
        end
        rst_n = 1'b1;
        n = 0;
        while (l_o !== 1'b0 && n < 20) begin
            tick();
            n++;
            checks++;
            if ({s_o, l_o, r_o, pulse} !== {m_out, m_pulse}) begin
                errors++;
                $display("FAIL reset_model: got %b want %b", {s_o, l_o, r_o, pulse}, {m_out, m_pulse});
            end
        end
        checks++;
        if (n != 6 || pulse !== 3'b010) begin
            errors++;
            $display("FAIL reset_latency: got edges=%0d pulse=%b want edges=6 pulse=010", n, pulse);
        end
        tick();
        checks++;
        if (pulse !== 3'b000 || l_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse_width: got pulse=%b left=%b want 000 0", pulse, l_o);
        end
        idle(10);
        checks++;
        if ({s_o, l_o, r_o, pulse} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_release_key: got %b want 111000", {s_o, l_o, r_o, pulse});
        end
    endtask

    task automatic test_glitch();
        r_raw = 1'b0;
        repeat (3) tick();
        r_raw = 1'b1;
        repeat (10) begin
            tick();
            checks++;
            if (r_o !== 1'b1 || pulse !== 3'b000) begin
                errors++;
                $display("FAIL glitch: got right=%b pulse=%b want 1 000", r_o, pulse);
            end
        end
    endtask

    task automatic test_bounce();
        int fall_at;
        int npulse;
        logic [3:0] pat;
        pat = 4'b0101;
        for (int k = 3; k >= 0; k--) begin
            s_raw = pat[k];
            tick();
        end
        s_raw = 1'b0;
        fall_at = -1;
        npulse = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (pulse != 3'b000) npulse++;
            if (s_o === 1'b0 && fall_at < 0) fall_at = k;
            checks++;
            if ({s_o, l_o, r_o, pulse} !== {m_out, m_pulse}) begin
                errors++;
                $display("FAIL bounce_model: got %b want %b", {s_o, l_o, r_o, pulse}, {m_out, m_pulse});
            end
        end
        checks++;
        if (fall_at != 6 || npulse != 1) begin
            errors++;
            $display("FAIL bounce_press: got fall=%0d pulses=%0d want 6 1", fall_at, npulse);
        end
        s_raw = 1'b1;
        npulse = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (pulse != 3'b000) npulse++;
            checks++;
            if (s_o !== (k == 6 ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL bounce_release: edge %0d got %b want %b", k, s_o, k == 6);
            end
        end
        checks++;
        if (npulse != 0) begin
            errors++;
            $display("FAIL release_pulse: got %0d pulses want 0", npulse);
        end
        idle(4);
    endtask

    task automatic test_simultaneous();
        int n;
        l_raw = 1'b0;
        r_raw = 1'b0;
        n = 0;
        while (l_o === 1'b1 && r_o === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if ({l_o, r_o, pulse} !== 5'b00011 || n != 6) begin
            errors++;
            $display("FAIL simultaneous: got lr=%b%b pulse=%b edges=%0d want 00 011 6", l_o, r_o, pulse, n);
        end
        tick();
        checks++;
        if (pulse !== 3'b000) begin
            errors++;
            $display("FAIL simultaneous_width: got %b want 000", pulse);
        end
        idle(10);
    endtask

    task automatic test_reset_midcount();
        int n;
        l_raw = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_o, l_o, r_o, pulse} !== 6'b111000) begin
            errors++;
            $display("FAIL midcount_reset: got %b want 111000", {s_o, l_o, r_o, pulse});
        end
        tick();
        rst_n = 1'b1;
        n = 0;
        while (l_o !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 6 || pulse !== 3'b010) begin
            errors++;
            $display("FAIL midcount_relatency: got edges=%0d pulse=%b want 6 010", n, pulse);
        end
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (l_o !== 1'b1 || pulse !== 3'b000) begin
            errors++;
            $display("FAIL pressed_async_reset: got left=%b pulse=%b want 1 000", l_o, pulse);
        end
        tick();
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_hold();
        int n;
        l_raw = 1'b0;
        n = 0;
        while (l_o !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 54; k++) begin
            if (k > 0) tick();
            checks++;
            if (AR) begin
                if (l_o !== ((k % 24) >= 20) || pulse[1] !== ((k % 24) == 0)) begin
                    errors++;
                    $display("FAIL autorepeat k=%0d: got left=%b pulse=%b", k, l_o, pulse[1]);
                end
            end else if (l_o !== 1'b0 || pulse[1] !== (k == 0)) begin
                errors++;
                $display("FAIL hold_single k=%0d: got left=%b pulse=%b", k, l_o, pulse[1]);
            end
        end
        idle(12);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) s_raw = ~s_raw;
            if ($urandom_range(0, 7) == 0) l_raw = ~l_raw;
            if ($urandom_range(0, 7) == 0) r_raw = ~r_raw;
            tick();
            checks++;
            if ({s_o, l_o, r_o, pulse} !== {m_out, m_pulse}) begin
                errors++;
                $display("FAIL random c=%0d: got %b want %b", c, {s_o, l_o, r_o, pulse}, {m_out, m_pulse});
            end
        end
        idle(12);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_midcount();
        test_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
